// File: rtl/pipe_reg_pkg.sv
// Shared types and defaults for the pipe_reg elastic pipeline.
package pipe_reg_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_STAGES = 1;

  // Occupancy of one skid stage: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg_stage.sv
// One elastic skid stage: main register feeds the output, skid register
// catches the beat that arrives while the output is stalled.
// Optional flush port when PIPE_REG_FLUSH_EN is defined.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef PIPE_REG_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  stage_state_t          state_q, state_d;
  logic                  valid_q, ready_q;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_fire, out_fire, flush;

`ifdef PIPE_REG_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_q & ready_i;

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = main_q;

  // State register; valid/ready are registered decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
    end
  end

  // Next-state logic from the upstream/downstream fire events.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:    if (out_fire) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath steering; flush leaves the data registers untouched.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (in_fire) main_d = data_i;
        BUSY: begin
          if (in_fire && out_fire) main_d = data_i;
          else if (in_fire)        skid_d = data_i;
        end
        FULL:    if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Payload registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule : pipe_reg_stage

// File: rtl/pipe_reg.sv
// Elastic pipeline register: NUM_STAGES chained skid stages with
// valid/ready on both sides, full throughput, 2*NUM_STAGES beats capacity.
// Define PIPE_REG_FLUSH_EN to add the synchronous flush_i pipeline drop.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef PIPE_REG_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (NUM_STAGES == 0) begin : g_bad_cfg
    $error("pipe_reg: NUM_STAGES must be at least 1");
  end

  // Handshake links; index k is the input side of stage k.
  logic                  link_valid [NUM_STAGES+1];
  logic                  link_ready [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] link_data  [NUM_STAGES+1];

  assign link_valid[0]          = valid_i;
  assign link_data[0]           = data_i;
  assign link_ready[NUM_STAGES] = ready_i;
  assign ready_o                = link_ready[0];
  assign valid_o                = link_valid[NUM_STAGES];
  assign data_o                 = link_data[NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    pipe_reg_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
`ifdef PIPE_REG_FLUSH_EN
      .flush_i (flush_i),
`endif
      .valid_i (link_valid[k]),
      .ready_o (link_ready[k]),
      .data_i  (link_data[k]),
      .valid_o (link_valid[k+1]),
      .ready_i (link_ready[k+1]),
      .data_o  (link_data[k+1])
    );
  end

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (NUM_STAGES=3, DATA_WIDTH=32) with an
// in-order scoreboard; flush steps run when PIPE_REG_FLUSH_EN is defined.
module tb_pipe_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i, flush_i;
  logic [DW-1:0] data_i;
  logic          valid_o, ready_o;
  logic [DW-1:0] data_o;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sbq [$];
  logic          last_in;
  logic [DW-1:0] nv;
  int            acc;

  always #5 clk = ~clk;

  pipe_reg #(
    .DATA_WIDTH(DW),
    .NUM_STAGES(NS)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
`ifdef PIPE_REG_FLUSH_EN
    .flush_i (flush_i),
`endif
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping before the edge, hold checks after.
  task automatic cycle();
    logic          inf, outf, hold, drop;
    logic [DW-1:0] held, din;
    drop = rst_i | flush_i;
    inf  = valid_i & ready_o;
    outf = valid_o & ready_i;
    hold = valid_o & ~ready_i;
    held = data_o;
    din  = data_i;
    if (outf === 1'b1 && !drop) begin
      if (sbq.size() == 0) begin
        chk32("sb_unexpected_out", data_o, 32'hFFFF_FFFF ^ data_o);
      end else begin
        chk32("sb_order", data_o, sbq[0]);
        void'(sbq.pop_front());
      end
    end
    if (inf === 1'b1 && !drop) sbq.push_back(din);
    @(posedge clk);
    #1;
    if (drop) sbq.delete();
    last_in = (inf === 1'b1) && !drop;
    if (hold === 1'b1 && !drop) begin
      chk1("hold_valid", valid_o, 1'b1);
      chk32("hold_data", data_o, held);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'hDEAD0000;
    ready_i = 1'b1;
    flush_i = 1'b0;
    last_in = 1'b0;

    // Reset dominates an offered beat.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("rst_valid", valid_o, 1'b0);
      chk32("rst_data", data_o, 32'h0);
      chk1("rst_ready", ready_o, 1'b1);
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1("idle_valid", valid_o, 1'b0);
      chk1("idle_ready", ready_o, 1'b1);
    end

    // Streaming: first beat out after edge 2 of its accept edge 0.
    ready_i = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      if (t < 8) begin
        valid_i = 1'b1;
        data_i  = 32'hAAAA0000 + 32'(t);
      end else begin
        valid_i = 1'b0;
      end
      cycle();
      if (t >= 2 && t <= 9) begin
        chk1("stream_valid", valid_o, 1'b1);
        chk32("stream_data", data_o, 32'hAAAA0000 + 32'(t - 2));
      end else begin
        chk1("stream_valid", valid_o, 1'b0);
      end
      chk1("stream_ready", ready_o, 1'b1);
    end

    // Backpressure: 6 beats fill 3 stages, ready_o drops after the 6th.
    ready_i = 1'b0;
    valid_i = 1'b1;
    nv      = 32'hBBBB0000;
    acc     = 0;
    for (int j = 0; j < 8; j++) begin
      data_i = nv;
      cycle();
      if (last_in) begin
        acc++;
        nv++;
      end
      chk1("bp_ready", ready_o, j < 5);
      chk1("bp_valid", valid_o, j >= 2);
      if (j >= 2) chk32("bp_data", data_o, 32'hBBBB0000);
    end
    chk32("bp_accepted", 32'(acc), 32'd6);

    // Release: output moves immediately, ready_o returns after 3 edges.
    ready_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      data_i = nv;
      cycle();
      if (last_in) nv++;
      if (j < 3) begin
        chk32("rel_data", data_o, 32'hBBBB0001 + 32'(j));
        chk1("rel_ready", ready_o, j == 2);
      end
      chk1("rel_valid", valid_o, 1'b1);
    end
    valid_i = 1'b0;
    for (int j = 0; j < 10; j++) cycle();
    chk1("rel_drain_valid", valid_o, 1'b0);
    chk32("rel_sb_empty", 32'(sbq.size()), 32'd0);

    // Random valid/ready traffic.
    for (int n = 0; n < 1000; n++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      data_i  = $urandom;
      cycle();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int j = 0; j < 12; j++) cycle();
    chk1("rand_drain_valid", valid_o, 1'b0);
    chk32("rand_sb_empty", 32'(sbq.size()), 32'd0);

`ifdef PIPE_REG_FLUSH_EN
    // Flush with three beats held and a fourth offered.
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      data_i = 32'hCCCC0000 + 32'(j);
      cycle();
    end
    flush_i = 1'b1;
    data_i  = 32'hCCCC0003;
    cycle();
    chk1("fl_valid", valid_o, 1'b0);
    chk1("fl_ready", ready_o, 1'b1);
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk1("fl_idle_valid", valid_o, 1'b0);
    end
    valid_i = 1'b1;
    data_i  = 32'h12345678;
    cycle();
    valid_i = 1'b0;
    cycle();
    cycle();
    chk1("fl_new_valid", valid_o, 1'b1);
    chk32("fl_new_data", data_o, 32'h12345678);
    cycle();
    chk1("fl_new_gone", valid_o, 1'b0);
`endif

    // Reset while completely stalled.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'hEEEE0000;
    for (int j = 0; j < 8; j++) cycle();
    chk1("stall_ready", ready_o, 1'b0);
    chk1("stall_valid", valid_o, 1'b1);
    rst_i = 1'b1;
    cycle();
    chk1("mrst_valid", valid_o, 1'b0);
    chk1("mrst_ready", ready_o, 1'b1);
    chk32("mrst_data", data_o, 32'h0);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk1("mrst_idle_valid", valid_o, 1'b0);
    end
    valid_i = 1'b1;
    data_i  = 32'h0F0F0F0F;
    cycle();
    valid_i = 1'b0;
    cycle();
    cycle();
    chk1("mrst_new_valid", valid_o, 1'b1);
    chk32("mrst_new_data", data_o, 32'h0F0F0F0F);
    cycle();
    chk1("mrst_new_gone", valid_o, 1'b0);
    chk32("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_reg
